game_status_tracker: RTL and testbench

Game-level bookkeeping for the asteroid display. It receives the per-asteroid score and health event toggles, keeps a saturating BCD score and a lives count, and sequences the game through idle, play, hit-flash and game-over. It drives the active-low object `enable` and the active-low object `reset` that every asteroid instance consumes, so it is the control end of the asteroid event interface.

---
 rtl/game_status_pkg.sv | 27 ++
 rtl/event_sync_edge.sv | 39 +++
 rtl/game_status_tracker.sv | 209 ++++++++++++++++++++
 tb/tb_game_status_tracker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_status_pkg.sv
// ---------------------------------------------------------------------------
// game_status_pkg
// Shared types and constants for the asteroid game status tracker:
//   state_t      - game sequencing states
//   bcd_digit_t  - one BCD score digit
//   MASK_LEN     - cycles after RESTART during which input events are masked
//   bcd_digit_inc- single-digit BCD increment (9 wraps to 0)
// ---------------------------------------------------------------------------
package game_status_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESTART   = 3'd1,
    PLAY      = 3'd2,
    HIT       = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned MASK_LEN = 3;

  function automatic bcd_digit_t bcd_digit_inc(input bcd_digit_t d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/event_sync_edge.sv
// ---------------------------------------------------------------------------
// event_sync_edge
// Two-flop synchronizer followed by a rising-edge detector for one
// asynchronous level input.
// Ports:
//   clk_i    - system clock
//   reset_i  - synchronous active-high reset
//   async_i  - asynchronous level input
//   mask_i   - suppresses edges; while high the previous-value flop is held
//              at 1 so a level that stays high across the mask never counts
//   edge_o   - one-cycle pulse per rising edge of the synchronized level
// ---------------------------------------------------------------------------
module event_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  input  logic mask_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= mask_i ? 1'b1 : sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q & ~mask_i;

endmodule

// File: rtl/game_status_tracker.sv
// ---------------------------------------------------------------------------
// game_status_tracker
// Game-level bookkeeping for the asteroid display: saturating BCD score,
// lives count and the IDLE/RESTART/PLAY/HIT/GAME_OVER sequence. It drives the
// active-low object enable and object reset consumed by every asteroid.
//
// Event interface: score_evt, health_evt and start_btn are asynchronous
// levels; each rising edge (after synchronization) is one event, however
// long the level stays high. There is no back-pressure.
//
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   frame_tick       - one-cycle pulse per frame (synchronous)
//   start_btn        - start/restart request (async level)
//   score_evt        - OR of asteroid score toggles (async level)
//   health_evt       - OR of asteroid health toggles (async level)
//   enable           - active-low object run enable (1 = frozen)
//   obj_reset_n      - active-low object reset, one-cycle pulse in RESTART
//   score_bcd        - BCD score, digit 0 in the low nibble
//   lives            - remaining lives
//   flash            - ship blink during post-hit invulnerability
//   game_over        - high in GAME_OVER
//   high_score_bcd   - best score, only with GAME_STATUS_HIGH_SCORE_EN
//   state_o          - current FSM state (debug)
//
// Build option: define GAME_STATUS_HIGH_SCORE_EN to add the high-score
// register and port.
// ---------------------------------------------------------------------------
module game_status_tracker
  import game_status_pkg::*;
#(
  parameter int unsigned SCORE_DIGITS = 4,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned FLASH_PERIOD = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      start_btn,
  input  logic                      score_evt,
  input  logic                      health_evt,
  output logic                      enable,
  output logic                      obj_reset_n,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [3:0]                lives,
  output logic                      flash,
  output logic                      game_over,
`ifdef GAME_STATUS_HIGH_SCORE_EN
  output logic [4*SCORE_DIGITS-1:0] high_score_bcd,
`endif
  output state_t                    state_o
);

  localparam int unsigned SW  = 4 * SCORE_DIGITS;
  localparam int unsigned FCW = $clog2(FLASH_FRAMES + 1);
  localparam int unsigned PCW = $clog2(FLASH_PERIOD + 1);
  localparam int unsigned MCW = $clog2(MASK_LEN + 1);

  localparam logic [3:0]     LIVES_INIT  = 4'(LIVES);
  localparam logic [FCW-1:0] FRAME_LAST  = FCW'(FLASH_FRAMES - 1);
  localparam logic [PCW-1:0] PERIOD_LAST = PCW'(FLASH_PERIOD - 1);
  localparam logic [MCW-1:0] MASK_INIT   = MCW'(MASK_LEN);

  state_t         state_q;
  logic           enable_q;
  logic           obj_reset_n_q;
  logic [SW-1:0]  score_q;
  logic [3:0]     lives_q;
  logic           flash_q;
  logic           game_over_q;
  logic [FCW-1:0] frame_cnt_q;
  logic [PCW-1:0] period_cnt_q;
  logic [MCW-1:0] mask_cnt_q;

  logic           mask;
  logic           start_edge;
  logic           score_edge;
  logic           health_edge;
  logic [SW-1:0]  score_inc;
  logic [SW-1:0]  score_d;
  logic           carry;

  // Masked during RESTART and the MASK_LEN cycles that follow it.
  assign mask = (state_q == RESTART) || (mask_cnt_q != '0);

  event_sync_edge u_sync_start  (.clk_i(clk), .reset_i(reset), .async_i(start_btn),
                                 .mask_i(mask), .edge_o(start_edge));
  event_sync_edge u_sync_score  (.clk_i(clk), .reset_i(reset), .async_i(score_evt),
                                 .mask_i(mask), .edge_o(score_edge));
  event_sync_edge u_sync_health (.clk_i(clk), .reset_i(reset), .async_i(health_evt),
                                 .mask_i(mask), .edge_o(health_edge));

  // Ripple BCD increment; a carry out of the top digit means every digit
  // was 9, so the score saturates instead of wrapping.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        score_inc[4*i +: 4] = bcd_digit_inc(score_q[4*i +: 4]);
        carry               = (score_q[4*i +: 4] == 4'd9);
      end
    end
    if (carry) score_inc = score_q;
  end

  // Score events only count while objects are running.
  assign score_d = (score_edge && (state_q == PLAY || state_q == HIT)) ? score_inc : score_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      enable_q      <= 1'b1;
      obj_reset_n_q <= 1'b1;
      score_q       <= '0;
      lives_q       <= LIVES_INIT;
      flash_q       <= 1'b0;
      game_over_q   <= 1'b0;
      frame_cnt_q   <= '0;
      period_cnt_q  <= '0;
      mask_cnt_q    <= '0;
    end else begin
      obj_reset_n_q <= 1'b1;
      if (state_q == RESTART)   mask_cnt_q <= MASK_INIT;
      else if (mask_cnt_q != '0) mask_cnt_q <= mask_cnt_q - MCW'(1);

      case (state_q)
        IDLE, GAME_OVER: begin
          if (start_edge) begin
            state_q       <= RESTART;
            obj_reset_n_q <= 1'b0;
            score_q       <= '0;
            lives_q       <= LIVES_INIT;
            flash_q       <= 1'b0;
            game_over_q   <= 1'b0;
          end
        end
        RESTART: begin
          state_q  <= PLAY;
          enable_q <= 1'b0;
        end
        PLAY: begin
          score_q <= score_d;
          if (health_edge) begin
            // Counters clear on HIT entry, so a tick in this cycle is not counted.
            frame_cnt_q  <= '0;
            period_cnt_q <= '0;
            flash_q      <= 1'b0;
            if (lives_q > 4'd1) begin
              lives_q <= lives_q - 4'd1;
              state_q <= HIT;
            end else begin
              lives_q     <= 4'd0;
              state_q     <= GAME_OVER;
              enable_q    <= 1'b1;
              game_over_q <= 1'b1;
            end
          end
        end
        HIT: begin
          score_q <= score_d;
          if (frame_tick) begin
            if (frame_cnt_q == FRAME_LAST) begin
              state_q <= PLAY;
              flash_q <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_q + FCW'(1);
              if (period_cnt_q == PERIOD_LAST) begin
                period_cnt_q <= '0;
                flash_q      <= ~flash_q;
              end else begin
                period_cnt_q <= period_cnt_q + PCW'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef GAME_STATUS_HIGH_SCORE_EN
  logic [SW-1:0] high_q;
  logic          go_entry;

  assign go_entry = (state_q == PLAY) && health_edge && (lives_q <= 4'd1);

  // Packed BCD with digits <= 9 orders the same as a plain unsigned compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_q <= '0;
    end else if (go_entry && (score_d > high_q)) begin
      high_q <= score_d;
    end
  end

  assign high_score_bcd = high_q;
`endif

  assign enable      = enable_q;
  assign obj_reset_n = obj_reset_n_q;
  assign score_bcd   = score_q;
  assign lives       = lives_q;
  assign flash       = flash_q;
  assign game_over   = game_over_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_game_status_tracker.sv
module tb_game_status_tracker;
  import game_status_pkg::*;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        start_btn;
  logic        score_evt;
  logic        health_evt;
  logic        enable;
  logic        obj_reset_n;
  logic [15:0] score_bcd;
  logic [3:0]  lives;
  logic        flash;
  logic        game_over;
  logic [15:0] high_score_bcd;
  state_t      state_o;

  // {enable, obj_reset_n, flash, game_over}
  logic [3:0]  ctl;
  assign ctl = {enable, obj_reset_n, flash, game_over};

  int total;
  int bad;
  int n_score;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  game_status_tracker #(
    .SCORE_DIGITS(4), .LIVES(3), .FLASH_FRAMES(4), .FLASH_PERIOD(2)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .score_evt(score_evt), .health_evt(health_evt), .enable(enable),
    .obj_reset_n(obj_reset_n), .score_bcd(score_bcd), .lives(lives),
    .flash(flash), .game_over(game_over),
`ifdef GAME_STATUS_HIGH_SCORE_EN
    .high_score_bcd(high_score_bcd),
`endif
    .state_o(state_o)
  );

`ifndef GAME_STATUS_HIGH_SCORE_EN
  assign high_score_bcd = '0;
`endif

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic health_pulse();
    health_evt = 1'b1;
    repeat (3) step();
    health_evt = 1'b0;
    repeat (3) step();
  endtask

  task automatic start_pulse();
    start_btn = 1'b1;
    repeat (2) step();
    start_btn = 1'b0;
    repeat (2) step();
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    v = (n > 9999) ? 9999 : n;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, 4'b1100); end
    total++; if (score_bcd !== 16'h0000) begin bad++; $display("FAIL reset_score: got %h want 0000", score_bcd); end
    total++; if (lives !== 4'd3) begin bad++; $display("FAIL reset_lives: got %0d want 3", lives); end
    total++; if (state_o !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_o, IDLE); end
`ifdef GAME_STATUS_HIGH_SCORE_EN
    total++; if (high_score_bcd !== 16'h0000) begin bad++; $display("FAIL reset_high: got %h want 0000", high_score_bcd); end
`endif
    reset = 1'b0;
    repeat (3) step();
    total++; if (state_o !== IDLE) begin bad++; $display("FAIL idle_hold: got %0d want %0d", state_o, IDLE); end
  endtask

  task automatic test_start();
    start_btn = 1'b1;
    repeat (2) step();
    total++; if (obj_reset_n !== 1'b1) begin bad++; $display("FAIL start_early: obj_reset_n got %b want 1", obj_reset_n); end
    start_btn = 1'b0;
    step();
    total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL restart_ctl: got %b want %b", ctl, 4'b1000); end
    total++; if (state_o !== RESTART) begin bad++; $display("FAIL restart_state: got %0d want %0d", state_o, RESTART); end
    step();
    total++; if (ctl !== 4'b0100) begin bad++; $display("FAIL play_ctl: got %b want %b", ctl, 4'b0100); end
    total++; if ({lives, score_bcd} !== {4'd3, 16'h0000}) begin bad++; $display("FAIL play_init: got %0d/%h want 3/0000", lives, score_bcd); end
    total++; if (state_o !== PLAY) begin bad++; $display("FAIL play_state: got %0d want %0d", state_o, PLAY); end
    repeat (4) step();
  endtask

  task automatic test_score();
    for (int k = 0; k < 12; k++) begin
      score_evt = 1'b1;
      n_score++;
      exp_q.push_back(to_bcd(n_score));
      repeat (2) step();
      total++; if (score_bcd !== to_bcd(n_score - 1)) begin bad++; $display("FAIL score_early: got %h want %h", score_bcd, to_bcd(n_score - 1)); end
      step();
      exp_v = exp_q.pop_front();
      total++; if (score_bcd !== exp_v) begin bad++; $display("FAIL score_update: got %h want %h", score_bcd, exp_v); end
      repeat (7) step();
      score_evt = 1'b0;
      repeat (3) step();
    end
    total++; if (score_bcd !== 16'h0012) begin bad++; $display("FAIL score_total: got %h want 0012", score_bcd); end
  endtask

  task automatic test_hit();
    health_evt = 1'b1;
    repeat (2) step();
    total++; if (lives !== 4'd3) begin bad++; $display("FAIL hit_early: got %0d want 3", lives); end
    frame_tick = 1'b1;  // lands in the HIT entry cycle: must not count
    step();
    frame_tick = 1'b0;
    total++; if (lives !== 4'd2) begin bad++; $display("FAIL hit_lives: got %0d want 2", lives); end
    total++; if (state_o !== HIT) begin bad++; $display("FAIL hit_state: got %0d want %0d", state_o, HIT); end
    total++; if (ctl !== 4'b0100) begin bad++; $display("FAIL hit_ctl: got %b want %b", ctl, 4'b0100); end
    health_evt = 1'b0;
    repeat (3) step();
    health_evt = 1'b1;
    repeat (4) step();
    health_evt = 1'b0;
    repeat (3) step();
    total++; if ({state_o, lives} !== {HIT, 4'd2}) begin bad++; $display("FAIL hit_invuln: got %0d/%0d want %0d/2", state_o, lives, HIT); end
    score_evt = 1'b1;
    n_score++;
    exp_q.push_back(to_bcd(n_score));
    repeat (3) step();
    exp_v = exp_q.pop_front();
    total++; if (score_bcd !== exp_v) begin bad++; $display("FAIL hit_score: got %h want %h", score_bcd, exp_v); end
    score_evt = 1'b0;
    repeat (3) step();
    for (int t = 1; t <= 4; t++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      total++; if (flash !== ((t == 2) || (t == 3))) begin bad++; $display("FAIL hit_flash_t%0d: got %b want %b", t, flash, (t == 2) || (t == 3)); end
      total++; if (state_o !== ((t == 4) ? PLAY : HIT)) begin bad++; $display("FAIL hit_exit_t%0d: got %0d want %0d", t, state_o, (t == 4) ? PLAY : HIT); end
      step();
    end
  endtask

  task automatic test_game_over();
    start_btn = 1'b1;
    repeat (4) step();
    start_btn = 1'b0;
    repeat (2) step();
    total++; if ({state_o, lives, score_bcd} !== {PLAY, 4'd2, to_bcd(n_score)}) begin bad++; $display("FAIL start_in_play: got %0d/%0d/%h want %0d/2/%h", state_o, lives, score_bcd, PLAY, to_bcd(n_score)); end
    health_pulse();
    total++; if ({state_o, lives} !== {HIT, 4'd1}) begin bad++; $display("FAIL last_hit: got %0d/%0d want %0d/1", state_o, lives, HIT); end
    run_ticks(4);
    total++; if (state_o !== PLAY) begin bad++; $display("FAIL last_hit_exit: got %0d want %0d", state_o, PLAY); end
    score_evt  = 1'b1;
    health_evt = 1'b1;
    n_score++;
    exp_q.push_back(to_bcd(n_score));
    repeat (2) step();
    total++; if (state_o !== PLAY) begin bad++; $display("FAIL go_early: got %0d want %0d", state_o, PLAY); end
    step();
    exp_v = exp_q.pop_front();
    total++; if (score_bcd !== exp_v) begin bad++; $display("FAIL go_score: got %h want %h", score_bcd, exp_v); end
    total++; if (lives !== 4'd0) begin bad++; $display("FAIL go_lives: got %0d want 0", lives); end
    total++; if (ctl !== 4'b1101) begin bad++; $display("FAIL go_ctl: got %b want %b", ctl, 4'b1101); end
    total++; if (state_o !== GAME_OVER) begin bad++; $display("FAIL go_state: got %0d want %0d", state_o, GAME_OVER); end
`ifdef GAME_STATUS_HIGH_SCORE_EN
    total++; if (high_score_bcd !== exp_v) begin bad++; $display("FAIL go_high: got %h want %h", high_score_bcd, exp_v); end
`endif
    score_evt  = 1'b0;
    health_evt = 1'b0;
    repeat (3) step();
    score_evt = 1'b1;
    repeat (4) step();
    score_evt = 1'b0;
    repeat (3) step();
    total++; if ({score_bcd, lives} !== {to_bcd(n_score), 4'd0}) begin bad++; $display("FAIL go_hold: got %h/%0d want %h/0", score_bcd, lives, to_bcd(n_score)); end
  endtask

  task automatic test_restart_held();
    start_btn = 1'b1;
    repeat (2) step();
    start_btn  = 1'b0;
    score_evt  = 1'b1;
    health_evt = 1'b1;
    step();
    total++; if (ctl !== 4'b1000) begin bad++; $display("FAIL rh_restart_ctl: got %b want %b", ctl, 4'b1000); end
    total++; if ({score_bcd, lives} !== {16'h0000, 4'd3}) begin bad++; $display("FAIL rh_cleared: got %h/%0d want 0000/3", score_bcd, lives); end
    step();
    total++; if (state_o !== PLAY) begin bad++; $display("FAIL rh_play: got %0d want %0d", state_o, PLAY); end
    repeat (8) step();
    n_score = 0;
    total++; if ({state_o, score_bcd, lives} !== {PLAY, 16'h0000, 4'd3}) begin bad++; $display("FAIL rh_masked: got %0d/%h/%0d want %0d/0000/3", state_o, score_bcd, lives, PLAY); end
    score_evt  = 1'b0;
    health_evt = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 9999; k++) begin
      score_evt = 1'b1;
      step();
      score_evt = 1'b0;
      step();
      n_score++;
    end
    exp_q.push_back(to_bcd(n_score));
    repeat (3) step();
    exp_v = exp_q.pop_front();
    total++; if (score_bcd !== exp_v) begin bad++; $display("FAIL sat_reach: got %h want %h", score_bcd, exp_v); end
    score_evt = 1'b1;
    step();
    score_evt = 1'b0;
    n_score++;
    exp_q.push_back(to_bcd(n_score));
    repeat (3) step();
    exp_v = exp_q.pop_front();
    total++; if (score_bcd !== exp_v) begin bad++; $display("FAIL sat_hold: got %h want %h", score_bcd, exp_v); end
    health_pulse();
    run_ticks(4);
    health_pulse();
    run_ticks(4);
    health_pulse();
    total++; if ({state_o, score_bcd} !== {GAME_OVER, 16'h9999}) begin bad++; $display("FAIL sat_go: got %0d/%h want %0d/9999", state_o, score_bcd, GAME_OVER); end
`ifdef GAME_STATUS_HIGH_SCORE_EN
    total++; if (high_score_bcd !== 16'h9999) begin bad++; $display("FAIL sat_high: got %h want 9999", high_score_bcd); end
`endif
    start_pulse();
    n_score = 0;
    total++; if ({state_o, score_bcd, lives} !== {PLAY, 16'h0000, 4'd3}) begin bad++; $display("FAIL sat_restart: got %0d/%h/%0d want %0d/0000/3", state_o, score_bcd, lives, PLAY); end
`ifdef GAME_STATUS_HIGH_SCORE_EN
    total++; if (high_score_bcd !== 16'h9999) begin bad++; $display("FAIL sat_high_kept: got %h want 9999", high_score_bcd); end
`endif
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    score_evt = 1'b1;
    step();
    score_evt = 1'b0;
    repeat (3) step();
    total++; if (score_bcd !== 16'h0001) begin bad++; $display("FAIL mid_pre: got %h want 0001", score_bcd); end
    reset = 1'b1;
    step();
    total++; if ({state_o, ctl, score_bcd, lives} !== {IDLE, 4'b1100, 16'h0000, 4'd3}) begin bad++; $display("FAIL mid_reset: got %0d/%b/%h/%0d want %0d/1100/0000/3", state_o, ctl, score_bcd, lives, IDLE); end
    total++; if (high_score_bcd !== 16'h0000) begin bad++; $display("FAIL mid_high: got %h want 0000", high_score_bcd); end
    reset = 1'b0;
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total      = 0;
    bad        = 0;
    n_score    = 0;
    reset      = 1'b1;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    score_evt  = 1'b0;
    health_evt = 1'b0;
    test_reset();
    test_start();
    test_score();
    test_hit();
    test_game_over();
    test_restart_held();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
